// File: rtl/mips_mem_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_mem_pkg;

    localparam int WORD_ADDR_W = 30;
    localparam int DATA_W      = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    typedef struct packed {
        logic                   rw;
        logic [WORD_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]      data;
    } mem_req_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Round-robin picker between fetch and data requests, data-only while locked.
// Latency: combinational.
// Backpressure: none; the caller samples the grant only when it is idle.
module mem_arb_pick
    import mips_mem_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  logic   lock_q,
    input  owner_t last_owner,
    output logic   grant_valid,
    output owner_t grant_owner
);

    always_comb begin
        grant_valid = d_req | (i_req & ~lock_q);
        grant_owner = OWN_D;
        // Fetch wins when alone, or on a tie when data owned the port last.
        if (!lock_q && i_req && (!d_req || last_owner == OWN_D)) begin
            grant_owner = OWN_I;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one word-addressed memory port between instruction fetch and data.
// Latency: write done 2 cycles after request, read done 2+MEM_LATENCY.
// Backpressure: requesters hold cs until their done pulse; the losing port waits.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int MEM_LATENCY  = 1,
    parameter int LOCK_TIMEOUT = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_cs_i,
    input  logic [WORD_ADDR_W-1:0] i_address_i,
    output logic [DATA_W-1:0]      i_data_o,
    output logic                   i_done_o,
    input  logic                   d_cs_i,
    input  logic                   d_rw_i,
    input  logic                   d_lock_i,
    input  logic [WORD_ADDR_W-1:0] d_address_i,
    input  logic [DATA_W-1:0]      d_data_i,
    output logic [DATA_W-1:0]      d_data_o,
    output logic                   d_done_o,
    output logic                   mem_cs_o,
    output logic                   mem_rw_o,
    output logic [WORD_ADDR_W-1:0] mem_address_o,
    output logic [DATA_W-1:0]      mem_data_o,
    input  logic [DATA_W-1:0]      mem_data_i
);

    localparam logic [2:0] LAT_LOAD = 3'(MEM_LATENCY - 1);
    localparam logic [7:0] TO_LAST  = 8'(LOCK_TIMEOUT - 1);

    arb_state_t  state_q, state_d;
    owner_t      owner_q, last_owner_q, grant_owner;
    logic        grant_valid, grant, capture;
    logic        lock_q;
    logic [2:0]  lat_q;
    logic [7:0]  to_q;
    mem_req_t    req_q;
    logic [DATA_W-1:0] i_data_q, d_data_q;

    mem_arb_pick u_pick (
        .i_req       (i_cs_i),
        .d_req       (d_cs_i),
        .lock_q      (lock_q),
        .last_owner  (last_owner_q),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    assign grant   = (state_q == IDLE) && grant_valid;
    assign capture = (state_q == WAIT) && (lat_q == 3'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        mem_cs_o = 1'b0;
        mem_rw_o = 1'b0;
        i_done_o = 1'b0;
        d_done_o = 1'b0;
        case (state_q)
            IDLE:   if (grant_valid) state_d = ACCESS;
            ACCESS: begin
                mem_cs_o = 1'b1;
                mem_rw_o = req_q.rw;
                state_d  = req_q.rw ? DONE : WAIT;
            end
            WAIT:   if (lat_q == 3'd0) state_d = DONE;
            DONE:   begin
                i_done_o = (owner_q == OWN_I);
                d_done_o = (owner_q == OWN_D);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q      <= OWN_I;
            last_owner_q <= OWN_D;
            lock_q       <= 1'b0;
            to_q         <= 8'd0;
            lat_q        <= 3'd0;
            req_q        <= '0;
            i_data_q     <= '0;
            d_data_q     <= '0;
        end else begin
            if (grant) begin
                owner_q      <= grant_owner;
                last_owner_q <= grant_owner;
                if (grant_owner == OWN_D) begin
                    req_q  <= '{rw: d_rw_i, addr: d_address_i, data: d_data_i};
                    lock_q <= d_lock_i;
                    to_q   <= 8'd0;
                end else begin
                    req_q.rw   <= 1'b0;
                    req_q.addr <= i_address_i;
                end
            end else if (state_q == IDLE && lock_q && !d_cs_i) begin
                // A pending data request is always granted instead, so it beats expiry.
                if (to_q == TO_LAST) begin
                    lock_q <= 1'b0;
                    to_q   <= 8'd0;
                end else begin
                    to_q <= to_q + 8'd1;
                end
            end

            if (state_q == ACCESS && !req_q.rw)  lat_q <= LAT_LOAD;
            else if (state_q == WAIT && lat_q != 3'd0) lat_q <= lat_q - 3'd1;

            if (capture) begin
                if (owner_q == OWN_I) i_data_q <= mem_data_i;
                else                  d_data_q <= mem_data_i;
            end
        end
    end

    assign i_data_o      = i_data_q;
    assign d_data_o      = d_data_q;
    assign mem_address_o = req_q.addr;
    assign mem_data_o    = req_q.data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected events into a
// scoreboard queue, a negedge monitor pops and checks each DUT access/done.
module tb_mem_port_arbiter;

    localparam int L = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_cs_i = 1'b0;
    logic [29:0] i_address_i = '0;
    logic [31:0] i_data_o;
    logic        i_done_o;
    logic        d_cs_i = 1'b0;
    logic        d_rw_i = 1'b0;
    logic        d_lock_i = 1'b0;
    logic [29:0] d_address_i = '0;
    logic [31:0] d_data_i = '0;
    logic [31:0] d_data_o;
    logic        d_done_o;
    logic        mem_cs_o;
    logic        mem_rw_o;
    logic [29:0] mem_address_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i = 32'hDEADBEEF;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    // kind: 0 = memory access, 1 = fetch done, 2 = data done
    typedef struct {
        int          kind;
        int          cyc;
        logic        rw;
        logic [29:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    mem_port_arbiter #(.MEM_LATENCY(L), .LOCK_TIMEOUT(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_cs_i        (i_cs_i),
        .i_address_i   (i_address_i),
        .i_data_o      (i_data_o),
        .i_done_o      (i_done_o),
        .d_cs_i        (d_cs_i),
        .d_rw_i        (d_rw_i),
        .d_lock_i      (d_lock_i),
        .d_address_i   (d_address_i),
        .d_data_i      (d_data_i),
        .d_data_o      (d_data_o),
        .d_done_o      (d_done_o),
        .mem_cs_o      (mem_cs_o),
        .mem_rw_o      (mem_rw_o),
        .mem_address_o (mem_address_o),
        .mem_data_o    (mem_data_o),
        .mem_data_i    (mem_data_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int c, input logic rw,
                        input logic [29:0] a, input logic [31:0] d);
        exp_t e;
        e.kind = kind; e.cyc = c; e.rw = rw; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic go(input int c);
        if (cyc > c) check("schedule", 32'(cyc), 32'(c));
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] mem_val(input logic [29:0] a);
        case (a)
            30'h100:      return 32'h8C220004;
            30'h200:      return 32'h01234567;
            30'h40:       return 32'hCAFEF00D;
            30'h20000000: return 32'hABCDEF12;
            default:      return 32'h0BAD0BAD;
        endcase
    endfunction

    // Memory model: read data is valid only during cycle (access + L).
    logic        pend = 1'b0;
    int          pend_cyc = 0;
    logic [29:0] pend_addr = '0;
    always @(negedge clk) begin
        if (pend && pend_cyc + L == cyc) begin
            mem_data_i = mem_val(pend_addr);
            pend = 1'b0;
        end else begin
            mem_data_i = 32'hDEADBEEF;
        end
        if (mem_cs_o && !mem_rw_o) begin
            pend = 1'b1;
            pend_cyc = cyc;
            pend_addr = mem_address_o;
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (!mem_cs_o) check("rw_idle", 32'(mem_rw_o), 32'd0);
            if (mem_cs_o || i_done_o || d_done_o) begin
                int   kind_act;
                exp_t e;
                kind_act = mem_cs_o ? 0 : (i_done_o ? 1 : 2);
                if (exp_q.size() == 0) begin
                    check("unexpected_event", 32'(kind_act), 32'hFFFFFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", 32'(kind_act), 32'(e.kind));
                    check("event_cycle", 32'(cyc), 32'(e.cyc));
                    if (kind_act == 0) begin
                        check("mem_rw", 32'(mem_rw_o), 32'(e.rw));
                        check("mem_addr", 32'(mem_address_o), 32'(e.addr));
                        if (e.rw) check("mem_wdata", mem_data_o, e.data);
                    end else if (kind_act == 1) begin
                        check("i_data", i_data_o, e.data);
                    end else begin
                        check("d_data", d_data_o, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        go(2);
        check("rst_mem_cs", 32'(mem_cs_o), 32'd0);
        check("rst_mem_rw", 32'(mem_rw_o), 32'd0);
        check("rst_mem_addr", 32'(mem_address_o), 32'd0);
        check("rst_mem_wdata", mem_data_o, 32'd0);
        check("rst_i_data", i_data_o, 32'd0);
        check("rst_d_data", d_data_o, 32'd0);
        check("rst_i_done", 32'(i_done_o), 32'd0);
        check("rst_d_done", 32'(d_done_o), 32'd0);
        go(3);
        rst_n = 1'b1;

        // Simultaneous requests from reset: I, D, I, D
        go(10);
        i_cs_i = 1'b1; i_address_i = 30'h100;
        d_cs_i = 1'b1; d_rw_i = 1'b0; d_address_i = 30'h40;
        push(0, 11, 1'b0, 30'h100, '0);
        push(1, 13, 1'b0, '0, 32'h8C220004);
        push(0, 15, 1'b0, 30'h40, '0);
        push(2, 17, 1'b0, '0, 32'hCAFEF00D);
        push(0, 19, 1'b0, 30'h200, '0);
        push(1, 21, 1'b0, '0, 32'h01234567);
        push(0, 23, 1'b0, 30'h40, '0);
        push(2, 25, 1'b0, '0, 32'hCAFEF00D);
        go(13); i_address_i = 30'h200;
        go(21); i_cs_i = 1'b0;
        go(25); d_cs_i = 1'b0;

        // Lone fetch read
        go(30);
        i_cs_i = 1'b1; i_address_i = 30'h100;
        push(0, 31, 1'b0, 30'h100, '0);
        push(1, 33, 1'b0, '0, 32'h8C220004);
        go(33); i_cs_i = 1'b0;

        // Data write leaves d_data_o alone
        go(40);
        d_cs_i = 1'b1; d_rw_i = 1'b1; d_address_i = 30'h20000000; d_data_i = 32'h12345678;
        push(0, 41, 1'b1, 30'h20000000, 32'h12345678);
        push(2, 42, 1'b0, '0, 32'hCAFEF00D);
        go(42); d_cs_i = 1'b0; d_rw_i = 1'b0;

        // Locked read-modify-write with fetch pending throughout
        go(50);
        d_cs_i = 1'b1; d_rw_i = 1'b0; d_lock_i = 1'b1; d_address_i = 30'h20000000;
        push(0, 51, 1'b0, 30'h20000000, '0);
        push(2, 53, 1'b0, '0, 32'hABCDEF12);
        push(0, 55, 1'b1, 30'h20000000, 32'hABCDFAAB);
        push(2, 56, 1'b0, '0, 32'hABCDEF12);
        push(0, 58, 1'b0, 30'h200, '0);
        push(1, 60, 1'b0, '0, 32'h01234567);
        go(51); i_cs_i = 1'b1; i_address_i = 30'h200;
        go(53); d_rw_i = 1'b1; d_data_i = 32'hABCDFAAB; d_lock_i = 1'b0;
        go(56); d_cs_i = 1'b0; d_rw_i = 1'b0;
        go(60); i_cs_i = 1'b0;

        // Lock timeout: fetch waits exactly 8 idle cycles
        go(70);
        d_cs_i = 1'b1; d_rw_i = 1'b0; d_lock_i = 1'b1; d_address_i = 30'h40;
        push(0, 71, 1'b0, 30'h40, '0);
        push(2, 73, 1'b0, '0, 32'hCAFEF00D);
        push(0, 83, 1'b0, 30'h100, '0);
        push(1, 85, 1'b0, '0, 32'h8C220004);
        go(73);
        d_cs_i = 1'b0; d_lock_i = 1'b0;
        i_cs_i = 1'b1; i_address_i = 30'h100;
        go(85); i_cs_i = 1'b0;

        // Reset during the WAIT of a fetch read
        go(90);
        i_cs_i = 1'b1; i_address_i = 30'h200;
        push(0, 91, 1'b0, 30'h200, '0);
        go(92);
        #2;
        rst_n = 1'b0;
        i_cs_i = 1'b0;
        #1;
        check("midrst_mem_cs", 32'(mem_cs_o), 32'd0);
        check("midrst_i_done", 32'(i_done_o), 32'd0);
        check("midrst_d_done", 32'(d_done_o), 32'd0);
        check("midrst_i_data", i_data_o, 32'd0);
        check("midrst_d_data", d_data_o, 32'd0);
        check("midrst_mem_addr", 32'(mem_address_o), 32'd0);
        go(95);
        rst_n = 1'b1;
        go(110);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single word-addressed data memory port between the instruction-fetch path and the data path. On the data side it sits behind the sub-word write synchroniser. The block grants one requester at a time and drives the memory for one access cycle. It captures read data after a fixed memory latency and returns a one-cycle done pulse to the owner. The data port can lock the memory across back-to-back transactions, so a read-modify-write sequence is never split by a fetch.

## Interface
- MEM_LATENCY, 1: cycles from the memory access cycle to valid mem_data_i; range 1..7.
- LOCK_TIMEOUT, 8: idle cycles a lock may hold with no data request before it is force-released; range 1..255.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_cs_i  in  1  fetch request; held until i_done_o.
- i_address_i  in  30  fetch word address.
- i_data_o  out  32  last fetched word.
- i_done_o  out  1  one-cycle completion pulse to the fetch port.
- d_cs_i  in  1  data request; held until d_done_o.
- d_rw_i  in  1  1 = write, 0 = read.
- d_lock_i  in  1  keep ownership after this transaction.
- d_address_i  in  30  data word address.
- d_data_i  in  32  write word.
- d_data_o  out  32  last word read by the data port.
- d_done_o  out  1  one-cycle completion pulse to the data port.
- mem_cs_o  out  1  memory select; high for exactly one cycle per access.
- mem_rw_o  out  1  1 = write.
- mem_address_o  out  30  memory word address.
- mem_data_o  out  32  memory write data.
- mem_data_i  in  32  memory read data.

## Operation
- States: IDLE, ACCESS, WAIT, DONE.
- **IDLE: arbitration**
  - Only one request pending: grant it.
  - Both pending: grant the port that was not last_owner (round-robin).
  - lock_q set: i_cs_i is ignored and only d_cs_i can be granted.
  - On grant, latch owner, rw, address and write data, update last_owner, then go to ACCESS.
  - The fetch port is always a read; its rw is forced to 0.
- **ACCESS**
  - Drive mem_cs_o=1 with the latched rw, address and data.
  - A write goes to DONE.
  - A read goes to WAIT with the latency counter loaded to MEM_LATENCY-1.
- **WAIT**
  - Decrement the counter each cycle.
  - When the counter is 0, capture mem_data_i into the owner's data register (i_data_o or d_data_o), then go to DONE.
- **DONE**
  - Pulse the owner's done_o, then go to IDLE.
  - The requester must drop cs, or present a new request, in the cycle after done.
- **Lock**
  - lock_q is set when a data grant is latched with d_lock_i=1.
  - lock_q is cleared when a data grant is latched with d_lock_i=0.
  - lock_q is also cleared when it has spent LOCK_TIMEOUT consecutive IDLE cycles with d_cs_i=0.
  - The timeout counter resets on every data grant.
- **Output holding**
  - i_data_o and d_data_o hold their value until the next read completes for that port.
  - A write never alters d_data_o.
  - mem_address_o and mem_data_o hold the last latched values outside ACCESS.
  - mem_rw_o is 0 whenever mem_cs_o is 0.
- **Reset values**
  - Every output is 0.
  - Internal state: IDLE, lock_q=0, counters 0.
  - last_owner = data, so the first simultaneous request goes to fetch.
- **Reset mid-transaction**
  - mem_cs_o drops asynchronously.
  - No done pulse is issued.
  - The interrupted requester must re-issue its request.

## Timing
- Request first sampled in IDLE at cycle N.
- ACCESS occurs at N+1.
- Write: done at N+2.
- Read: mem_data_i is sampled at cycle N+1+MEM_LATENCY and done is at N+2+MEM_LATENCY; the data output is valid from that cycle onward.
- Minimum spacing between two memory accesses is 3 cycles for writes and 3+MEM_LATENCY cycles for reads.
- Worst-case fetch wait with no lock is one data transaction.
- Worst-case fetch wait with a lock is the locked sequence plus LOCK_TIMEOUT.
- Simultaneous events:
  - Lock expiry in the same cycle as a new d_cs_i: the data request wins and the lock is not cleared.
  - A request arriving in DONE is not sampled until IDLE.

## Structure
- Shared package mips_mem_pkg holds:
  - WORD_ADDR_W=30 and DATA_W=32;
  - state encodings IDLE=0, ACCESS=1, WAIT=2, DONE=3;
  - owner encoding OWN_I=0, OWN_D=1.
- One sub-module, mem_arb_pick: combinational round-robin picker.
  - Inputs: i_req, d_req, lock_q, last_owner.
  - Outputs: grant_valid, grant_owner.
- The FSM, latency counter, lock/timeout logic and output registers live in the top level.

## Test plan
- **Fetch read, MEM_LATENCY=1:**
  - i_cs_i=1, address 0x0000100, memory returns 0x8C220004.
  - Expected: mem_cs_o high one cycle at N+1; i_done_o at N+3; i_data_o=0x8C220004; d_done_o never high.
- **Data write:**
  - d_cs_i=1, d_rw_i=1, address 0x20000000, data 0x12345678.
  - Expected: mem_cs_o=1 and mem_rw_o=1 at N+1 with that address and data; d_done_o at N+2; d_data_o unchanged.
- **Simultaneous requests from reset:**
  - Expected: fetch granted first, then data.
  - Repeat both requests held: grants alternate I, D, I, D.
- **Locked read-modify-write:**
  - Data read to 0x20000000 with d_lock_i=1 returns 0xABCDEF12, then data write 0xABCDFAAB with d_lock_i=0, with i_cs_i held high throughout.
  - Expected: fetch is not granted until after the write's d_done_o.
- **Lock timeout:**
  - Data read with d_lock_i=1, then d_cs_i stays low while i_cs_i=1.
  - Expected: fetch is granted exactly after 8 IDLE cycles.
- **Reset mid-read:**
  - Assert rst_n=0 during WAIT.
  - Expected: mem_cs_o, i_done_o, d_done_o and the data outputs are 0 immediately, with no done pulse after release.
